matrix_dac_loader: RTL and testbench
====================================

MATRIX_DAC_LOADER -- requirements
Module: matrix_dac_loader

Interface
REQ-001 SHALL have parameter N_CH, default 8: number of input-RAM channels, range 1..16.
REQ-002 SHALL have parameter DAT_W, default 256: RAM word width.
REQ-003 SHALL have parameter IN_ADRS_W, default 6: input-RAM address width.
REQ-004 SHALL have parameter COE_ADRS_W, default 13: coefficient-RAM address width, at least IN_ADRS_W.
REQ-005 SHALL have parameter AUTO_TRG, default 1: 1 issues trg automatically once all RAMs are loaded.
REQ-006 SHALL have parameter TRG_LEN, default 4: trg pulse length in cycles, at least 1.
REQ-007 SHALL have one clock and a synchronous, active-high reset.
REQ-008 clk_250MHz  in  1  sole clock; all logic on the rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 cfg_start  in  1  one-cycle pulse requesting a load job.
REQ-011 cfg_coe  in  1  1 = job targets the coefficient RAM; 0 = job targets the input RAM selected by cfg_ch.
REQ-012 cfg_ch  in  4  target channel index.
REQ-013 cfg_base  in  COE_ADRS_W  first write address.
REQ-014 cfg_len  in  COE_ADRS_W+1  word count.
REQ-015 s_valid / s_ready / s_data  in / out / in  1 / 1 / DAT_W  data stream; a beat transfers when s_valid and s_ready are both 1.
REQ-016 ram_wen  out  N_CH  per-channel input-RAM write enable.
REQ-017 ram_wadrs / ram_wdat  out  IN_ADRS_W / DAT_W  shared input-RAM address and data.
REQ-018 coe_wen / coe_wadrs / coe_wdat  out  1 / COE_ADRS_W / DAT_W  coefficient-RAM write port.
REQ-019 loaded  out  N_CH+1  sticky per-RAM loaded flags; bit N_CH is the coefficient RAM.
REQ-020 trg  out  1  active-high trigger to the matrix/DAC core.
REQ-021 busy / done / err  out  1 each  busy is a level; done and err are one-cycle pulses.

Function
REQ-022 SHALL implement a state machine with states IDLE, LOAD and TRIG.
REQ-023 In IDLE, cfg_start SHALL be checked for: cfg_len==0; cfg_coe==0 with cfg_ch>=N_CH; cfg_base+cfg_len (computed COE_ADRS_W+2 bits wide) exceeding the target depth (2^IN_ADRS_W for a channel, 2^COE_ADRS_W for coefficients).
REQ-024 If any REQ-023 check fails, err SHALL pulse on the next cycle, no write SHALL occur, and the state SHALL stay IDLE.
REQ-025 If all REQ-023 checks pass, the block SHALL latch target, pointer=cfg_base and remaining=cfg_len, then enter LOAD next cycle.
REQ-026 cfg_start SHALL be ignored in LOAD and TRIG: no err, no effect.
REQ-027 s_ready SHALL equal 1 exactly while in LOAD; in IDLE and TRIG it SHALL be 0.
REQ-028 Each accepted beat SHALL produce, on the next cycle, a one-cycle write on the target: for a channel, ram_wen[ch]=1 with ram_wadrs=pointer[IN_ADRS_W-1:0]; for coefficients, coe_wen=1 with coe_wadrs=pointer.
REQ-029 Each write SHALL carry the beat's s_data on its wdat output, then pointer SHALL increment and remaining SHALL decrement.
REQ-030 Every other ram_wen bit and the unused port's enable SHALL stay 0 during a write.
REQ-031 The beat that makes remaining 0 SHALL cause done to pulse in the same cycle as its write.
REQ-032 That final beat SHALL also set the target's loaded bit in that cycle and leave LOAD.
REQ-033 After LOAD, the next state SHALL be TRIG if AUTO_TRG=1 and all N_CH+1 loaded bits are set; otherwise it SHALL be IDLE.
REQ-034 TRIG SHALL hold trg=1 for exactly TRG_LEN cycles, then clear all loaded bits and return to IDLE on the same edge.
REQ-035 Reloading an already-loaded RAM SHALL be legal and SHALL leave its loaded bit set.
REQ-036 busy SHALL be 1 in LOAD and TRIG and 0 in IDLE.
REQ-037 A gap in s_valid during LOAD SHALL stall the job without losing or duplicating a write.

Reset
REQ-038 While rst=1, the state SHALL be IDLE and all outputs (ram_wen, ram_wadrs, ram_wdat, coe_wen, coe_wadrs, coe_wdat, loaded, trg, busy, done, err, s_ready) SHALL be 0.
REQ-039 rst asserted mid-LOAD SHALL stop writes from the next edge, drop the job, and leave the target's loaded bit clear.
REQ-040 rst asserted mid-TRIG SHALL force trg to 0 on the next edge.

Verification
REQ-041 Load ch3, base 60, len 4, continuous beats D0..D3 -> ram_wen[3] high at addresses 60..63 carrying D0..D3; done with the 63 write; loaded=0x008.
REQ-042 Load ch2 with cfg_base=62 and cfg_len=3 -> err for 1 cycle, no write, busy stays 0; a separate request with cfg_ch=9 (N_CH=8) -> err for 1 cycle.
REQ-043 Coefficient load, base 0, len 8192, with s_valid toggling every other cycle -> exactly 8192 coe_wen writes at addresses 0..8191, ram_wen stays 0, done once.
REQ-044 AUTO_TRG=1: load ch0..7 then coefficients -> trg high 4 cycles starting the cycle after the final done, then loaded=0 and busy=0.
REQ-045 rst asserted after the 2nd beat of a len-10 job -> no further writes, all outputs 0, loaded bit clear; a new job is accepted after rst deasserts.
REQ-046 cfg_start pulsed during LOAD -> ignored: no err, and the current job completes unchanged.

Source files
------------

// File: rtl/matrix_dac_loader.sv
// matrix_dac_loader: streams words into N_CH input RAMs and one coefficient RAM,
// tracks which RAMs hold fresh data and fires a trigger once everything is loaded. Rev 1.0
`default_nettype none

module matrix_dac_loader #(
  parameter int N_CH       = 8,
  parameter int DAT_W      = 256,
  parameter int IN_ADRS_W  = 6,
  parameter int COE_ADRS_W = 13,
  parameter int AUTO_TRG   = 1,
  parameter int TRG_LEN    = 4
) (
  input  logic                  clk_250MHz,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_coe,
  input  logic [3:0]            cfg_ch,
  input  logic [COE_ADRS_W-1:0] cfg_base,
  input  logic [COE_ADRS_W:0]   cfg_len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DAT_W-1:0]      s_data,
  output logic [N_CH-1:0]       ram_wen,
  output logic [IN_ADRS_W-1:0]  ram_wadrs,
  output logic [DAT_W-1:0]      ram_wdat,
  output logic                  coe_wen,
  output logic [COE_ADRS_W-1:0] coe_wadrs,
  output logic [DAT_W-1:0]      coe_wdat,
  output logic [N_CH:0]         loaded,
  output logic                  trg,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int LW    = N_CH + 1;
  localparam int EW    = COE_ADRS_W + 2;
  localparam int CNT_W = $clog2(TRG_LEN + 1);
  localparam logic [EW-1:0]    IN_DEPTH  = EW'(1) << IN_ADRS_W;
  localparam logic [EW-1:0]    COE_DEPTH = EW'(1) << COE_ADRS_W;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TRG_LEN);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, TRIG = 2'd2} state_t;

  state_t                state, state_nxt;
  logic                  tgt_coe;
  logic [3:0]            tgt_ch;
  logic [COE_ADRS_W-1:0] ptr;
  logic [COE_ADRS_W:0]   remaining;
  logic [CNT_W-1:0]      trg_cnt;

  logic [EW-1:0] cfg_end;
  logic [EW-1:0] depth;
  logic          cfg_bad;
  logic [LW-1:0] tgt_mask;
  logic          start_ok, start_bad, beat, last;

  assign cfg_end  = {2'b00, cfg_base} + {1'b0, cfg_len};
  assign depth    = cfg_coe ? COE_DEPTH : IN_DEPTH;
  assign cfg_bad  = (cfg_len == '0)
                  || (!cfg_coe && ({1'b0, cfg_ch} >= 5'(N_CH)))
                  || (cfg_end > depth);
  assign tgt_mask = tgt_coe ? (LW'(1) << N_CH) : (LW'(1) << tgt_ch);

  // Handshake and busy are gated by rst so they read 0 for the whole reset window.
  assign s_ready = (state == LOAD) && !rst;
  assign busy    = (state != IDLE) && !rst;

  always_ff @(posedge clk_250MHz) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    beat      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_bad) begin
            start_bad = 1'b1;
          end else begin
            start_ok  = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (s_valid) begin
          beat = 1'b1;
          if (remaining == (COE_ADRS_W+1)'(1)) begin
            last = 1'b1;
            // The bit being set by this final beat counts towards the trigger.
            state_nxt = ((AUTO_TRG != 0) && (&(loaded | tgt_mask))) ? TRIG : IDLE;
          end
        end
      end
      TRIG: begin
        if (trg_cnt == CNT_MAX) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_250MHz) begin
    if (rst) begin
      tgt_coe   <= 1'b0;
      tgt_ch    <= '0;
      ptr       <= '0;
      remaining <= '0;
      trg_cnt   <= '0;
      ram_wen   <= '0;
      ram_wadrs <= '0;
      ram_wdat  <= '0;
      coe_wen   <= 1'b0;
      coe_wadrs <= '0;
      coe_wdat  <= '0;
      loaded    <= '0;
      trg       <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ram_wen <= '0;
      coe_wen <= 1'b0;
      done    <= 1'b0;
      err     <= start_bad;
      if (start_ok) begin
        tgt_coe   <= cfg_coe;
        tgt_ch    <= cfg_ch;
        ptr       <= cfg_base;
        remaining <= cfg_len;
      end
      if (beat) begin
        if (tgt_coe) begin
          coe_wen   <= 1'b1;
          coe_wadrs <= ptr;
          coe_wdat  <= s_data;
        end else begin
          ram_wen   <= N_CH'(1) << tgt_ch;
          ram_wadrs <= ptr[IN_ADRS_W-1:0];
          ram_wdat  <= s_data;
        end
        ptr       <= ptr + 1'b1;
        remaining <= remaining - 1'b1;
        if (last) begin
          done    <= 1'b1;
          loaded  <= loaded | tgt_mask;
          trg_cnt <= '0;
        end
      end
      if (state == TRIG) begin
        if (trg_cnt == CNT_MAX) begin
          trg    <= 1'b0;
          loaded <= '0;
        end else begin
          trg     <= 1'b1;
          trg_cnt <= trg_cnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matrix_dac_loader.sv
// tb_matrix_dac_loader: randomized load jobs checked against a write-list / loaded-mask model.
`default_nettype none

module tb_matrix_dac_loader;

  localparam int N_CH = 8;
  localparam int DW   = 256;
  localparam int IAW  = 6;
  localparam int CAW  = 13;
  localparam int TLEN = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_start, cfg_coe;
  logic [3:0]     cfg_ch;
  logic [CAW-1:0] cfg_base;
  logic [CAW:0]   cfg_len;
  logic           s_valid, s_ready;
  logic [DW-1:0]  s_data;
  logic [N_CH-1:0] ram_wen;
  logic [IAW-1:0] ram_wadrs;
  logic [DW-1:0]  ram_wdat;
  logic           coe_wen;
  logic [CAW-1:0] coe_wadrs;
  logic [DW-1:0]  coe_wdat;
  logic [N_CH:0]  loaded;
  logic           trg, busy, done, err;

  matrix_dac_loader #(
    .N_CH(N_CH), .DAT_W(DW), .IN_ADRS_W(IAW), .COE_ADRS_W(CAW), .AUTO_TRG(1), .TRG_LEN(TLEN)
  ) dut (
    .clk_250MHz(clk), .rst(rst), .cfg_start(cfg_start), .cfg_coe(cfg_coe), .cfg_ch(cfg_ch),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .ram_wen(ram_wen), .ram_wadrs(ram_wadrs), .ram_wdat(ram_wdat), .coe_wen(coe_wen),
    .coe_wadrs(coe_wadrs), .coe_wdat(coe_wdat), .loaded(loaded), .trg(trg), .busy(busy),
    .done(done), .err(err)
  );

  always #2 clk = ~clk;

  typedef struct {
    bit            coe;
    int            ch;
    int            adr;
    logic [DW-1:0] d;
    bit            last;
  } wr_t;

  wr_t            exp_q[$];
  wr_t            e_mon;
  logic [N_CH:0]  loaded_m = '0;
  bit             err_win = 1'b0;
  int             n_checks = 0;
  int             n_errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit is_bad(input bit coe, input int ch, input int base, input int len);
    int dep;
    dep = coe ? (1 << CAW) : (1 << IAW);
    return (len == 0) || (!coe && ch >= N_CH) || (base + len > dep);
  endfunction

  // Every write the DUT emits must be the next entry of the expected write list.
  always @(negedge clk) begin
    if (ram_wen != '0 || coe_wen) begin
      if (exp_q.size() == 0) begin
        chk("wr_spurious", DW'({ram_wen, coe_wen}), '0);
      end else begin
        e_mon = exp_q.pop_front();
        if (e_mon.coe) begin
          chk("coe_wen", DW'(coe_wen), 1);
          chk("ram_wen_idle", DW'(ram_wen), 0);
          chk("coe_adr", DW'(coe_wadrs), DW'(e_mon.adr));
          chk("coe_dat", coe_wdat, e_mon.d);
        end else begin
          chk("ram_wen", DW'(ram_wen), DW'(1) << e_mon.ch);
          chk("coe_wen_idle", DW'(coe_wen), 0);
          chk("ram_adr", DW'(ram_wadrs), DW'(e_mon.adr));
          chk("ram_dat", ram_wdat, e_mon.d);
        end
        chk("done_at_wr", DW'(done), DW'(e_mon.last));
      end
    end else if (done) begin
      chk("done_spurious", DW'(done), 0);
    end
    if (err && !err_win) chk("err_spurious", DW'(err), 0);
  end

  task automatic bad_req(input bit coe, input int ch, input int base, input int len);
    err_win = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_coe = coe; cfg_ch = 4'(ch); cfg_base = CAW'(base); cfg_len = (CAW+1)'(len);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(negedge clk);
    chk("err_pulse", DW'(err), 1);
    chk("err_busy", DW'(busy), 0);
    @(negedge clk);
    chk("err_clear", DW'(err), 0);
    err_win = 1'b0;
  endtask

  // mode: 0 continuous, 1 valid every other cycle, 2 random gaps.
  task automatic run_job(input bit coe, input int ch, input int base, input int len,
                         input int mode, input int abort_at, input bit poke);
    logic [DW-1:0] dq[$];
    logic [N_CH:0] mask;
    int  n, i, cyc;
    bit  xfer;
    n = (abort_at > 0) ? abort_at : len;
    for (int k = 0; k < len; k++) begin
      dq.push_back(rnd());
      if (k < n) exp_q.push_back('{coe, ch, base + k, dq[k], k == len - 1});
    end
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_coe = coe; cfg_ch = 4'(ch); cfg_base = CAW'(base); cfg_len = (CAW+1)'(len);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    i = 0; cyc = 0;
    while (i < n) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = cyc[0];
        default: s_valid = ($urandom_range(3) != 0);
      endcase
      s_data = dq[i];
      if (poke && cyc == 3) begin
        cfg_start = 1'b1; cfg_len = '0; cfg_ch = 4'd15;
      end else begin
        cfg_start = 1'b0;
      end
      @(negedge clk);
      xfer = s_valid && s_ready;
      @(posedge clk); #1;
      if (xfer) i++;
      cyc++;
      if (cyc > 4 * len + 50) begin
        chk("beat_timeout", DW'(i), DW'(n));
        break;
      end
    end
    s_valid = 1'b0; cfg_start = 1'b0;
    if (abort_at > 0) begin
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_ctl", DW'({ram_wen, ram_wadrs, coe_wen, coe_wadrs, loaded, trg, busy, done, err, s_ready}), 0);
      chk("rst_rdat", ram_wdat, 0);
      chk("rst_cdat", coe_wdat, 0);
      loaded_m = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end
    mask = coe ? ((N_CH+1)'(1) << N_CH) : ((N_CH+1)'(1) << ch);
    loaded_m = loaded_m | mask;
    @(negedge clk);
    chk("loaded", DW'(loaded), DW'(loaded_m));
    chk("trg_at_done", DW'(trg), 0);
    if (&loaded_m) begin
      for (int k = 0; k < TLEN; k++) begin
        @(negedge clk);
        chk("trg_hi", DW'(trg), 1);
        chk("trg_busy", DW'(busy), 1);
      end
      @(negedge clk);
      loaded_m = '0;
      chk("trg_lo", DW'(trg), 0);
      chk("trg_loaded_clr", DW'(loaded), 0);
      chk("trg_busy_lo", DW'(busy), 0);
    end else begin
      @(negedge clk);
      chk("idle_busy", DW'(busy), 0);
      chk("idle_ready", DW'(s_ready), 0);
    end
  endtask

  initial begin
    int ch, base, len;
    rst = 1'b1; cfg_start = 1'b0; cfg_coe = 1'b0; cfg_ch = '0; cfg_base = '0; cfg_len = '0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", DW'({ram_wen, ram_wadrs, coe_wen, coe_wadrs, loaded, trg, busy, done, err, s_ready}), 0);
    chk("reset_dat", ram_wdat | coe_wdat, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_job(0, 3, 60, 4, 0, 0, 0);
    chk("loaded_ch3", DW'(loaded), DW'(9'h008));

    bad_req(0, 2, 62, 3);
    bad_req(0, 9, 0, 1);
    bad_req(0, 0, 0, 0);
    bad_req(1, 0, 8000, 193);

    run_job(0, 1, 10, 8, 0, 0, 1);

    for (int t = 0; t < 12; t++) begin
      ch   = $urandom_range(0, 9);
      base = $urandom_range(0, 63);
      len  = $urandom_range(0, 40);
      if (is_bad(1'b0, ch, base, len)) bad_req(0, ch, base, len);
      else                             run_job(0, ch, base, len, 2, 0, 0);
    end

    run_job(0, 5, 0, 10, 0, 2, 0);
    run_job(0, 4, 0, 3, 2, 0, 0);
    chk("after_rst_loaded", DW'(loaded), DW'(9'h010));

    for (int c = 0; c < N_CH; c++) run_job(0, c, c * 4, 2 + c, 2, 0, 0);
    run_job(1, 0, 0, 8192, 1, 0, 0);

    repeat (3) @(posedge clk);
    chk("exp_q_empty", DW'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
